data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Shares the single-port data RAM between two requesters: port 0 (CPU core data path) and port 1 (external loader/debug master). Grants at most one access per cycle with round-robin fairness, plus a bounded lock so the core can keep the RAM for multi-cycle sequences (CALL/RET stack traffic). Sits between the requesters and the `ram` instance. A denied requester sees `o_pX_ready`=0 and stalls.

## Interface
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 16, RAM data width
- `LOCK_MAX`, 16, maximum consecutive cycles a port may hold a lock (≥2)

- `i_clk` in 1: sole clock, all state on rising edge
- `i_reset` in 1: synchronous, active-high reset
- `i_p0_valid` / `i_p1_valid` in 1: request present
- `i_p0_write` / `i_p1_write` in 1: 1 = write, 0 = read
- `i_p0_lock` / `i_p1_lock` in 1: keep ownership after this access
- `i_p0_addr` / `i_p1_addr` in ADDR_WIDTH: request address
- `i_p0_data` / `i_p1_data` in DATA_WIDTH: write data
- `o_p0_ready` / `o_p1_ready` out 1: request accepted this cycle
- `o_p0_rvalid` / `o_p1_rvalid` out 1: read data valid this cycle
- `o_p0_rdata` / `o_p1_rdata` out DATA_WIDTH: read data, 0 when rvalid=0
- `o_ram_load` out 1: RAM write enable
- `o_ram_addr` out ADDR_WIDTH: RAM address
- `o_ram_data` out DATA_WIDTH: RAM write data
- `i_ram_data` in DATA_WIDTH: RAM read data, valid one cycle after address

## Operation
- FSM states: IDLE, OWN0, OWN1, RELEASE. Regs: `state`, `last_grant` (1 bit), `lock_cnt`, `resp_port`/`resp_valid`.
- IDLE: one port valid → grant it. Both valid → grant `!last_grant`. Grant updates `last_grant`.
- Accept = ready & valid in the same cycle. The RAM bus is driven combinationally from the granted port. Write sets `o_ram_load`=1. No grant → addr/data/load all 0.
- Grant with lock=1 → next state OWNx, `lock_cnt`=1.
- OWNx: only port x can be granted, and only port x's ready can be 1. The other port's ready is 0 even if RAM is idle.
  - Port x with lock=0 (with or without valid; an access that cycle is still served) → IDLE.
  - `lock_cnt`==LOCK_MAX-1 with lock still high → RELEASE.
  - Otherwise `lock_cnt`++.
- RELEASE lasts one cycle. Port x ready=0. The other port is granted if valid; its lock bit is ignored. Then → IDLE with `last_grant`=other port, so x wins the next tie.
- Requester rule: hold valid/write/addr/data/lock stable until ready. The arbiter does not check this.

## Timing
- Zero-cycle grant: ready is combinational from valids, state and `last_grant`. There is no path from ready back into valid.
- Read accepted in cycle N → `o_pX_rvalid`=1 and `o_pX_rdata`=`i_ram_data` in cycle N+1 on the granting port only.
- Back-to-back reads are pipelined: one accept per cycle, one response per cycle.
- Writes produce no response. Reads and writes interleave freely.
- Reset values: state IDLE, `last_grant`=1 (port 0 wins the first tie), `lock_cnt`=0, rvalid both 0, rdata both 0. RAM outputs are 0 while no valid.
- Reset asserted in the cycle after a read accept → that rvalid is suppressed (response dropped). Reset asserted while in OWNx → IDLE.
- Both valid in OWNx: only x served. Starvation of the other port is bounded by LOCK_MAX+1 cycles.

## Structure
- Package `ram_arb_pkg` holds:
  - state encoding localparams `ARB_IDLE`=0, `ARB_OWN0`=1, `ARB_OWN1`=2, `ARB_RELEASE`=3
  - port index constants `PORT_CORE`=0, `PORT_EXT`=1
- One sub-module, `arb_rr2`: combinational two-input round-robin picker. Inputs: two requests and `last_grant`. Outputs: one-hot grant.
- FSM, lock counter, response register and bus mux live in `data_ram_arbiter`.

## Test plan
- Single port: p0 writes 0x1234 @0x10, then reads @0x10 → o_ram_load=1 in cycle 0; o_p0_rvalid=1 and rdata=0x1234 in the cycle after the read accept.
- Contention: both request reads every cycle from reset (p0 @0x01, p1 @0x02) → grants alternate p0, p1, p0, …; each rvalid lands on the correct port one cycle later.
- Lock: p0 does 3 locked accesses then lock=0, while p1 is valid throughout → p1 ready=0 for all 4 p0 cycles; p1 is granted in the next cycle.
- Lock timeout: LOCK_MAX=4, p0 holds lock and valid indefinitely, p1 valid → p0 is served 4 cycles, then RELEASE grants p1, then p0 wins the following tie.
- Reset mid-read: p1 read accepted, i_reset=1 next cycle → o_p1_rvalid=0; state IDLE; first tie afterwards goes to p0.
- Idle bus: no valids for 10 cycles → o_ram_load=0, o_ram_addr=0, both ready=0, no rvalid.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data RAM arbiter: FSM state encoding,
// requester port indices and a small helper for port selection.
package ram_arb_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_OWN0    = 2'd1;
    localparam logic [1:0] ARB_OWN1    = 2'd2;
    localparam logic [1:0] ARB_RELEASE = 2'd3;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_EXT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = ARB_IDLE,
        ST_OWN0    = ARB_OWN0,
        ST_OWN1    = ARB_OWN1,
        ST_RELEASE = ARB_RELEASE
    } arb_state_e;

    // The port that is not p; used when a lock is forcibly released.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker. On a tie the port that did not win
// last time is chosen; a lone request always wins.
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant selection, favouring the port that lost most recently.
    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = (i_last_grant == PORT_EXT) ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU core (port 0) and
// the external loader/debug master (port 1). Grants are combinational
// (zero-cycle), fair round-robin on ties, and a port may lock the RAM
// for a bounded number of cycles. Read data returns one cycle after the
// accept on the port that issued the read.
module data_ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  i_p0_valid,
    input  logic                  i_p0_write,
    input  logic                  i_p0_lock,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_data,
    output logic                  o_p0_ready,
    output logic                  o_p0_rvalid,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,

    input  logic                  i_p1_valid,
    input  logic                  i_p1_write,
    input  logic                  i_p1_lock,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_data,
    output logic                  o_p1_ready,
    output logic                  o_p1_rvalid,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,

    output logic                  o_ram_load,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam int CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_port_q, resp_port_d;

    logic [1:0]       rr_grant;
    logic [1:0]       grant;
    logic             p0_rvalid;
    logic             p1_rvalid;

    arb_rr2 u_rr (
        .i_req0       (i_p0_valid),
        .i_req1       (i_p1_valid),
        .i_last_grant (last_grant_q),
        .o_grant      (rr_grant)
    );

    // Next-state, grant and lock-counter logic; no grants while in reset.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        grant        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                grant      = rr_grant;
                lock_cnt_d = '0;
                if (rr_grant[0]) begin
                    last_grant_d = PORT_CORE;
                    if (i_p0_lock) begin
                        state_d    = ST_OWN0;
                        lock_cnt_d = CNT_W'(1);
                    end
                end else if (rr_grant[1]) begin
                    last_grant_d = PORT_EXT;
                    if (i_p1_lock) begin
                        state_d    = ST_OWN1;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end

            ST_OWN0: begin
                grant[0] = i_p0_valid;
                if (!i_p0_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ST_RELEASE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end

            ST_OWN1: begin
                grant[1] = i_p1_valid;
                if (!i_p1_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ST_RELEASE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                // last_grant still names the port whose lock timed out.
                if (last_grant_q == PORT_CORE) begin
                    grant[1] = i_p1_valid;
                end else begin
                    grant[0] = i_p0_valid;
                end
                last_grant_d = other_port(last_grant_q);
                lock_cnt_d   = '0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase

        if (i_reset) begin
            grant = 2'b00;
        end
    end

    // RAM bus mux driven straight from the granted requester.
    always_comb begin
        o_ram_load = 1'b0;
        o_ram_addr = '0;
        o_ram_data = '0;
        if (grant[0]) begin
            o_ram_load = i_p0_write;
            o_ram_addr = i_p0_addr;
            o_ram_data = i_p0_data;
        end else if (grant[1]) begin
            o_ram_load = i_p1_write;
            o_ram_addr = i_p1_addr;
            o_ram_data = i_p1_data;
        end
    end

    // Remember which port issued an accepted read so its data is routed back.
    always_comb begin
        resp_valid_d = (grant[0] && !i_p0_write) || (grant[1] && !i_p1_write);
        resp_port_d  = grant[1] ? PORT_EXT : PORT_CORE;
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_EXT;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_port_q  <= PORT_CORE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
        end
    end

    // Response outputs; a response due during a reset cycle is dropped.
    always_comb begin
        p0_rvalid  = resp_valid_q && (resp_port_q == PORT_CORE) && !i_reset;
        p1_rvalid  = resp_valid_q && (resp_port_q == PORT_EXT) && !i_reset;
        o_p0_ready = grant[0];
        o_p1_ready = grant[1];
        o_p0_rvalid = p0_rvalid;
        o_p1_rvalid = p1_rvalid;
        o_p0_rdata  = p0_rvalid ? i_ram_data : '0;
        o_p1_rdata  = p1_rvalid ? i_ram_data : '0;
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter with LOCK_MAX=4. Grants and
// bus contents are checked per cycle against hand-derived tables; read
// responses go through a scoreboard queue checked by a response monitor.
module tb_data_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LM = 4;
    localparam int BW = 3 + AW + DW;

    typedef struct packed {
        logic          valid;
        logic          write;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          p0_valid, p0_write, p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;
    logic          p1_valid, p1_write, p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;
    logic          o_p0_ready, o_p0_rvalid, o_p1_ready, o_p1_rvalid;
    logic [DW-1:0] o_p0_rdata, o_p1_rdata;
    logic          o_ram_load;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_data;
    logic [DW-1:0] ram_rdata;

    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    resp_t         sb[$];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] mem [256];
    logic          ram_clear;
    logic          mon_en = 1'b0;
    logic          mon_v0, mon_v1;
    logic [DW-1:0] mon_d;
    resp_t         mon_e;

    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_p0_valid  (p0_valid),
        .i_p0_write  (p0_write),
        .i_p0_lock   (p0_lock),
        .i_p0_addr   (p0_addr),
        .i_p0_data   (p0_data),
        .o_p0_ready  (o_p0_ready),
        .o_p0_rvalid (o_p0_rvalid),
        .o_p0_rdata  (o_p0_rdata),
        .i_p1_valid  (p1_valid),
        .i_p1_write  (p1_write),
        .i_p1_lock   (p1_lock),
        .i_p1_addr   (p1_addr),
        .i_p1_data   (p1_data),
        .o_p1_ready  (o_p1_ready),
        .o_p1_rvalid (o_p1_rvalid),
        .o_p1_rdata  (o_p1_rdata),
        .o_ram_load  (o_ram_load),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .i_ram_data  (ram_rdata)
    );

    // Cycle counter used to time-stamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (o_ram_load) mem[o_ram_addr] <= o_ram_data;
            ram_rdata <= mem[o_ram_addr];
        end
    end

    // Response monitor: each cycle the rvalid/rdata pair on both ports must
    // match whatever the scoreboard says is due now (or be silent).
    always @(negedge clk) begin
        if (mon_en) begin
            mon_v0 = 1'b0;
            mon_v1 = 1'b0;
            mon_d  = '0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                fails++;
                $display("[TB] FAIL rsp_missed cyc%0d port%0d data %h never checked", cyc, mon_e.port, mon_e.data);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.port) mon_v1 = 1'b1;
                else            mon_v0 = 1'b1;
                mon_d = mon_e.data;
            end
            checks++;
            if (o_p0_rvalid !== mon_v0 || o_p0_rdata !== (mon_v0 ? mon_d : '0)) begin
                fails++;
                $display("[TB] FAIL rsp_p0 cyc%0d got v=%b d=%h exp v=%b d=%h", cyc, o_p0_rvalid, o_p0_rdata, mon_v0, mon_v0 ? mon_d : '0);
            end
            checks++;
            if (o_p1_rvalid !== mon_v1 || o_p1_rdata !== (mon_v1 ? mon_d : '0)) begin
                fails++;
                $display("[TB] FAIL rsp_p1 cyc%0d got v=%b d=%h exp v=%b d=%h", cyc, o_p1_rvalid, o_p1_rdata, mon_v1, mon_v1 ? mon_d : '0);
            end
        end
    end

    function automatic req_t mk(input logic v, input logic w, input logic l,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.valid = v; r.write = w; r.lock = l; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic applyStimulus(input req_t r0, input req_t r1);
        p0_valid = r0.valid; p0_write = r0.write; p0_lock = r0.lock;
        p0_addr  = r0.addr;  p0_data  = r0.data;
        p1_valid = r1.valid; p1_write = r1.write; p1_lock = r1.lock;
        p1_addr  = r1.addr;  p1_data  = r1.data;
    endtask

    // Drive one cycle with the expected grant g (0 none, 1 port0, 2 port1),
    // record the expected bus image and queue any expected read response.
    task automatic run_cycle(input req_t r0, input req_t r1, input int g, output logic [BW-1:0] exp_bus);
        req_t rg;
        @(posedge clk); #1;
        applyStimulus(r0, r1);
        rg = (g == 1) ? r0 : (g == 2) ? r1 : '0;
        exp_bus = {g == 1, g == 2, (g != 0) && rg.write, rg.addr, rg.data};
        if (g != 0) begin
            if (rg.write) shadow[rg.addr] = rg.data;
            else sb.push_back('{port: (g == 2), data: shadow[rg.addr], due: cyc + 1});
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        applyStimulus('0, '0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [BW-1:0] got;
        i_reset   = 1'b1;
        ram_clear = 1'b1;
        applyStimulus('0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
        checks++;
        if (got !== '0 || o_p0_rvalid !== 1'b0 || o_p1_rvalid !== 1'b0 || o_p0_rdata !== '0 || o_p1_rdata !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got bus=%h rv=%b%b rd=%h/%h exp all zero", got, o_p0_rvalid, o_p1_rvalid, o_p0_rdata, o_p1_rdata);
        end
        @(posedge clk); #1;
        i_reset   = 1'b0;
        ram_clear = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
        checks++;
        if (got !== '0) begin
            fails++;
            $display("[TB] FAIL post_reset_bus got %h exp 0", got);
        end
    endtask

    task automatic test_single_port();
        req_t s0[6], s1[6];
        int g[6];
        logic [BW-1:0] exp_bus, got;
        s0[0] = mk(1, 1, 0, 8'h10, 16'h1234); s1[0] = '0;                           g[0] = 1;
        s0[1] = mk(1, 0, 0, 8'h10, 16'h0000); s1[1] = '0;                           g[1] = 1;
        s0[2] = mk(1, 1, 0, 8'h01, 16'hA5A5); s1[2] = '0;                           g[2] = 1;
        s0[3] = '0;                           s1[3] = mk(1, 1, 0, 8'h02, 16'hBEEF); g[3] = 2;
        s0[4] = '0;                           s1[4] = mk(1, 0, 0, 8'h02, 16'h0000); g[4] = 2;
        s0[5] = mk(1, 0, 0, 8'h01, 16'h0000); s1[5] = '0;                           g[5] = 1;
        for (int i = 0; i < 6; i++) begin
            run_cycle(s0[i], s1[i], g[i], exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus) begin
                fails++;
                $display("[TB] FAIL single_port step%0d got rdy/load/addr/data=%h exp %h", i, got, exp_bus);
            end
        end
    endtask

    task automatic test_contention();
        logic [BW-1:0] exp_bus, got;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            run_cycle(mk(1, 0, 0, 8'h01, 16'h0), mk(1, 0, 0, 8'h02, 16'h0), (i % 2 == 0) ? 1 : 2, exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus) begin
                fails++;
                $display("[TB] FAIL contention step%0d got %h exp %h", i, got, exp_bus);
            end
        end
    endtask

    task automatic test_lock();
        req_t s0[6];
        int g[6];
        req_t p1r;
        logic [BW-1:0] exp_bus, got;
        p1r   = mk(1, 0, 0, 8'h02, 16'h0);
        s0[0] = mk(1, 1, 1, 8'h20, 16'h1111); g[0] = 1;
        s0[1] = mk(1, 1, 1, 8'h21, 16'h2222); g[1] = 1;
        s0[2] = mk(1, 0, 1, 8'h20, 16'h0000); g[2] = 1;
        s0[3] = mk(1, 0, 0, 8'h21, 16'h0000); g[3] = 1;
        s0[4] = mk(1, 0, 0, 8'h10, 16'h0000); g[4] = 2;
        s0[5] = mk(1, 0, 0, 8'h10, 16'h0000); g[5] = 1;
        for (int i = 0; i < 6; i++) begin
            run_cycle(s0[i], (i == 5) ? mk(1, 0, 0, 8'h01, 16'h0) : p1r, g[i], exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus) begin
                fails++;
                $display("[TB] FAIL lock step%0d got %h exp %h", i, got, exp_bus);
            end
        end
    endtask

    task automatic test_lock_timeout();
        req_t s0[8], s1[8];
        int g[8];
        logic [BW-1:0] exp_bus, got;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            s0[i] = mk(1, 0, 1, 8'h10, 16'h0);
            s1[i] = mk(1, 0, 1, 8'h02, 16'h0);
            g[i]  = (i == 4) ? 2 : 1;
        end
        s0[6] = '0; s1[6] = mk(1, 0, 0, 8'h02, 16'h0); g[6] = 0;
        s0[7] = '0; s1[7] = mk(1, 0, 0, 8'h02, 16'h0); g[7] = 2;
        for (int i = 0; i < 8; i++) begin
            run_cycle(s0[i], s1[i], g[i], exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus) begin
                fails++;
                $display("[TB] FAIL lock_timeout step%0d got %h exp %h", i, got, exp_bus);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [BW-1:0] exp_bus, got;
        run_cycle('0, mk(1, 0, 1, 8'h02, 16'h0), 2, exp_bus);
        got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
        checks++;
        if (got !== exp_bus) begin
            fails++;
            $display("[TB] FAIL midrd_accept got %h exp %h", got, exp_bus);
        end
        sb.delete(sb.size() - 1);
        @(posedge clk); #1;
        applyStimulus('0, '0);
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_p1_rvalid !== 1'b0 || o_p1_rdata !== '0) begin
            fails++;
            $display("[TB] FAIL midrd_drop got rvalid=%b rdata=%h exp 0/0", o_p1_rvalid, o_p1_rdata);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_cycle(mk(1, 0, 0, 8'h10, 16'h0), mk(1, 0, 0, 8'h02, 16'h0), i + 1, exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus) begin
                fails++;
                $display("[TB] FAIL midrd_tie step%0d got %h exp %h", i, got, exp_bus);
            end
        end
    endtask

    task automatic test_idle();
        logic [BW-1:0] exp_bus, got;
        for (int i = 0; i < 10; i++) begin
            run_cycle('0, '0, 0, exp_bus);
            got = {o_p0_ready, o_p1_ready, o_ram_load, o_ram_addr, o_ram_data};
            checks++;
            if (got !== exp_bus || {o_p0_rvalid, o_p1_rvalid} !== 2'b00 && i > 0) begin
                fails++;
                $display("[TB] FAIL idle step%0d got bus=%h rv=%b%b exp bus=%h rv=00", i, got, o_p0_rvalid, o_p1_rvalid, exp_bus);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        test_reset();
        test_single_port();
        test_contention();
        test_lock();
        test_lock_timeout();
        test_reset_mid_read();
        test_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_drain got %0d pending responses exp 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
